// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin arbiter sharing one external combinational multiplier
//
// Purpose: up to NREQ requesters each present an operand pair; one is granted at a
// time by round-robin, its operands are driven to an external combinational
// multiplier, and the full-width unsigned product is returned with the owner index.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NREQ]       per-requester operand valid
//   req_a/req_b  in   [NREQ*W]     flattened operands, requester i at [i*W +: W]
//   req_ready    out  [NREQ]       one-hot acceptance strobe (operands taken this cycle)
//   mul_a/mul_b  out  [W]          operands to the shared multiplier
//   mul_product  in   [2*W]        product from the shared multiplier
//   rsp_valid    out               result valid
//   rsp_id       out  [clog2 NREQ] owner of the result
//   rsp_product  out  [2*W]        registered product
//   rsp_ready    in                consumer accepts the result

module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_product,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [2*W-1:0]    rsp_product,
    input  logic              rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;   // first index searched on the next arbitration
    logic [IW-1:0] op_id;    // owner of the operands currently on mul_a/mul_b

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   rr_sum;
    logic [IW-1:0] rr_idx;

    // Round-robin search starting at rr_ptr, wrapping at NREQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IW+1)'(NREQ);
            end
            rr_idx = rr_sum[IW-1:0];
            if (!gnt_found && req_valid[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx;
            end
        end
    end

    // The acceptance strobe must coincide with the cycle the operands are latched,
    // so it is decoded from the registered state; gating with rst_n keeps it low
    // while reset is held even if requests are pending.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_found) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_id       <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // mul_a/mul_b only change on a grant, so the multiplier inputs
                    // stay quiet while requesters wiggle their operands.
                    if (gnt_found) begin
                        mul_a  <= req_a[gnt_idx*W +: W];
                        mul_b  <= req_b[gnt_idx*W +: W];
                        op_id  <= gnt_idx;
                        rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    rsp_product <= mul_product;
                    rsp_id      <= op_id;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - directed scoreboard bench for mult_share_arb

module tb_mult_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [15:0]   req_a;
    logic [15:0]   req_b;
    logic [3:0]    req_ready;
    logic [3:0]    mul_a;
    logic [3:0]    mul_b;
    logic [7:0]    mul_product;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [7:0]    rsp_product;
    logic          rsp_ready;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [15:0]   sb_q[$];   // {id[15:8], product[7:0]}

    mult_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready)
    );

    // Shared multiplier model.
    assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    // Called in an IDLE cycle where requester id is expected to win.
    task automatic run_op(input int id, input logic [7:0] prod, input bit clr);
        #1;
        chk("grant", {28'b0, req_ready}, 32'(1 << id));
        sb_q.push_back({8'(id), prod});
        tick;
        if (clr) req_valid = '0;
        #1;
        chk("mul_ready_zero", {28'b0, req_ready}, 0);
        chk("mul_no_rsp", {31'b0, rsp_valid}, 0);
        tick;
        #1;
        chk("resp_valid", {31'b0, rsp_valid}, 1);
        chk("resp_id", {30'b0, rsp_id}, 32'(id));
        chk("resp_prod", {24'b0, rsp_product}, {24'b0, prod});
        chk("resp_ready_zero", {28'b0, req_ready}, 0);
        tick;
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
            logic [15:0] e;
            chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_id", {30'b0, rsp_id}, {24'b0, e[15:8]});
                chk("sb_prod", {24'b0, rsp_product}, {24'b0, e[7:0]});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick;
        tick;

        // Reset state, with requests pending during reset.
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", {28'b0, req_ready}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_id", {30'b0, rsp_id}, 0);
        chk("rst_rsp_product", {24'b0, rsp_product}, 0);
        chk("rst_mul_a", {28'b0, mul_a}, 0);
        chk("rst_mul_b", {28'b0, mul_b}, 0);
        tick;
        rst_n = 1'b1;

        // All four requesting continuously: 0,1,2,3,0 every 3 cycles.
        for (int k = 0; k < 5; k++) begin
            run_op(k % 4, 8'(((k % 4) + 1) * 3), k == 4);
        end

        // Single request, then withdrawal of req 1 during the busy period.
        set_op(0, 4'd1, 4'd1);
        req_valid = 4'b0001;
        #1;
        chk("single_grant", {28'b0, req_ready}, 32'h1);
        sb_q.push_back({8'd0, 8'h01});
        tick;
        set_op(1, 4'd7, 4'd7);
        set_op(3, 4'd6, 4'd5);
        req_valid = 4'b1010;
        #1;
        chk("single_mul_a", {28'b0, mul_a}, 1);
        chk("single_mul_b", {28'b0, mul_b}, 1);
        chk("busy_ready_zero", {28'b0, req_ready}, 0);
        tick;
        req_valid = 4'b1000;
        #1;
        chk("single_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("single_rsp_id", {30'b0, rsp_id}, 0);
        chk("single_rsp_prod", {24'b0, rsp_product}, 32'h01);
        tick;
        set_op(0, 4'hF, 4'hE);
        #1;
        chk("idle_hold_a", {28'b0, mul_a}, 1);
        chk("idle_hold_b", {28'b0, mul_b}, 1);
        run_op(3, 8'd30, 1'b1);

        // Boundary operands.
        set_op(0, 4'hF, 4'hF);
        req_valid = 4'b0001;
        run_op(0, 8'hE1, 1'b1);
        set_op(0, 4'h0, 4'hF);
        req_valid = 4'b0001;
        run_op(0, 8'h00, 1'b1);

        // Back-pressure with a request arriving while busy.
        rsp_ready = 1'b0;
        set_op(2, 4'd4, 4'd4);
        req_valid = 4'b0100;
        #1;
        chk("bp_grant", {28'b0, req_ready}, 32'h4);
        sb_q.push_back({8'd2, 8'h10});
        tick;
        set_op(0, 4'd2, 4'd5);
        req_valid = 4'b0001;
        tick;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
            chk("bp_rsp_prod", {24'b0, rsp_product}, 32'h10);
            chk("bp_rsp_id", {30'b0, rsp_id}, 2);
            chk("bp_ready_zero", {28'b0, req_ready}, 0);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", {31'b0, rsp_valid}, 1);
        tick;
        #1;
        chk("bp_idle_rsp_valid", {31'b0, rsp_valid}, 0);
        run_op(0, 8'd10, 1'b1);

        // Reset in MUL with requests pending; the pointer returns to 0.
        set_op(1, 4'd3, 4'd3);
        set_op(3, 4'd5, 4'd2);
        req_valid = 4'b1010;
        #1;
        chk("pre_rst_grant", {28'b0, req_ready}, 32'h2);
        tick;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", {28'b0, req_ready}, 0);
        chk("mrst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mrst_rsp_product", {24'b0, rsp_product}, 0);
        chk("mrst_rsp_id", {30'b0, rsp_id}, 0);
        chk("mrst_mul_a", {28'b0, mul_a}, 0);
        chk("mrst_mul_b", {28'b0, mul_b}, 0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("post_rst_no_rsp", {31'b0, rsp_valid}, 0);
        run_op(1, 8'd9, 1'b1);

        repeat (3) tick;
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
